// File: rtl/appliance_pkg.sv
// Shared types and defaults for the appliance controller.
// State codes are fixed because they leave the block on state_o.
package appliance_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DOOR  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [31:0] RUN_CYCLES_DEF  = 32'd1_500_000_000;
    localparam logic [31:0] BEEP_CYCLES_DEF = 32'd12_500_000;
    localparam int          CNT_W_DEF       = 32;

endpackage

// File: rtl/appliance_if.sv
// Debounced switch levels in, motor/LED/buzzer drives out.
// master drives the switches; slave is the controller.
interface appliance_if;

    logic       on_db;
    logic       off_db;
    logic       err_db;
    logic       open_db;
    logic       motor_en;
    logic       led_run;
    logic       led_door;
    logic       led_fault;
    logic       buzzer;
    logic [1:0] state_o;
    logic       done_pulse;

    modport master (
        output on_db,
        output off_db,
        output err_db,
        output open_db,
        input  motor_en,
        input  led_run,
        input  led_door,
        input  led_fault,
        input  buzzer,
        input  state_o,
        input  done_pulse
    );

    modport slave (
        input  on_db,
        input  off_db,
        input  err_db,
        input  open_db,
        output motor_en,
        output led_run,
        output led_door,
        output led_fault,
        output buzzer,
        output state_o,
        output done_pulse
    );

endinterface

// File: rtl/appliance_ctrl_beep_gen.sv
// Buzzer driver: fixed-length beeps, restartable, plus fault alarm.
// alarm_en takes over the counter; dropping it silences the buzzer.
module beep_gen
    import appliance_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter logic [31:0] BEEP_CYCLES = BEEP_CYCLES_DEF
) (
    input  logic clk_50MHz,
    input  logic reset_n,
    input  logic beep_req,
    input  logic alarm_en,
    output logic buzzer
);

    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 32'd1);

    logic [CNT_W-1:0] beep_cnt_q, beep_cnt_d;
    logic             buzzer_q, buzzer_d;
    logic             alarm_q, alarm_d;

    always_comb begin
        beep_cnt_d = beep_cnt_q;
        buzzer_d   = buzzer_q;
        alarm_d    = alarm_en;
        if (alarm_en) begin
            // First alarm cycle starts high regardless of any beep in flight
            if (!alarm_q) begin
                buzzer_d   = 1'b1;
                beep_cnt_d = '0;
            end else if (beep_cnt_q == BEEP_LAST) begin
                buzzer_d   = ~buzzer_q;
                beep_cnt_d = '0;
            end else begin
                beep_cnt_d = beep_cnt_q + CNT_W'(1);
            end
        end else if (alarm_q) begin
            buzzer_d   = 1'b0;
            beep_cnt_d = '0;
        end else if (beep_req) begin
            buzzer_d   = 1'b1;
            beep_cnt_d = '0;
        end else if (buzzer_q) begin
            if (beep_cnt_q == BEEP_LAST) begin
                buzzer_d   = 1'b0;
                beep_cnt_d = '0;
            end else begin
                beep_cnt_d = beep_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            beep_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= buzzer_d;
            alarm_q    <= alarm_d;
        end
    end

    assign buzzer = buzzer_q;

endmodule

// File: rtl/appliance_ctrl.sv
// Appliance sequencer: idle, timed run, door pause and fault states.
// Consumes debounced switch levels; owns the run timer.
module appliance_ctrl
    import appliance_pkg::*;
#(
    parameter logic [31:0] RUN_CYCLES  = RUN_CYCLES_DEF,
    parameter logic [31:0] BEEP_CYCLES = BEEP_CYCLES_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    appliance_if.slave  io
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 32'd1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             on_q, off_q;
    logic             done_q, done_d;
    logic             on_rise, off_rise;
    logic             beep_req;
    logic             alarm_en;
    logic             buzzer;

    assign on_rise  = io.on_db & ~on_q;
    assign off_rise = io.off_db & ~off_q;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        done_d    = 1'b0;
        beep_req  = 1'b0;
        if (io.err_db) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (on_rise) begin
                        beep_req = 1'b1;
                        if (!io.open_db) begin
                            state_d   = RUN;
                            run_cnt_d = '0;
                        end
                    end
                end
                RUN: begin
                    if (off_rise) begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                    end else if (io.open_db) begin
                        state_d = DOOR;
                    end else if (run_cnt_q == RUN_LAST) begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                        done_d    = 1'b1;
                        beep_req  = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end
                end
                DOOR: begin
                    // Closing the door alone keeps the pause; ON resumes
                    if (off_rise) begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                    end else if (on_rise && !io.open_db) begin
                        state_d = RUN;
                    end
                end
                FAULT: begin
                    if (off_rise) begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Alarm tracks the next state so the buzzer moves with state_o
    assign alarm_en = (state_d == FAULT);

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            done_q    <= 1'b0;
            on_q      <= io.on_db;
            off_q     <= io.off_db;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            done_q    <= done_d;
            on_q      <= io.on_db;
            off_q     <= io.off_db;
        end
    end

    beep_gen #(
        .CNT_W       (CNT_W),
        .BEEP_CYCLES (BEEP_CYCLES)
    ) u_beep (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .beep_req  (beep_req),
        .alarm_en  (alarm_en),
        .buzzer    (buzzer)
    );

    assign io.state_o    = state_q;
    assign io.motor_en   = (state_q == RUN);
    assign io.led_run    = (state_q == RUN);
    assign io.led_door   = (state_q == DOOR);
    assign io.led_fault  = (state_q == FAULT);
    assign io.buzzer     = buzzer;
    assign io.done_pulse = done_q;

endmodule

// File: tb/tb_appliance_ctrl.sv
// Scoreboard bench for appliance_ctrl with RUN_CYCLES=20, BEEP_CYCLES=4.
// Each stimulus cycle queues the expected output vector for that edge.
module tb_appliance_ctrl;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    appliance_if ifc ();

    appliance_ctrl #(
        .RUN_CYCLES  (32'd20),
        .BEEP_CYCLES (32'd4),
        .CNT_W       (32)
    ) dut (
        .clk_50MHz (clk),
        .reset_n   (rst_n),
        .io        (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ev(logic [1:0] s, logic b, logic d);
        return {s, s == 2'd1, s == 2'd1, s == 2'd2, s == 2'd3, b, d};
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag,
                {ifc.state_o, ifc.motor_en, ifc.led_run, ifc.led_door,
                 ifc.led_fault, ifc.buzzer, ifc.done_pulse},
                e.v);
        end
    end

    task automatic cyc(string tag, logic [1:0] s, logic b, logic d);
        exp_t e;
        @(posedge clk);
        e.tag = tag;
        e.v   = ev(s, b, d);
        sb.push_back(e);
        #1;
    endtask

    task automatic rep(string tag, logic [1:0] s, logic b, logic d, int n);
        for (int i = 0; i < n; i++) cyc(tag, s, b, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ifc.on_db   = 1'b1;
        ifc.off_db  = 1'b0;
        ifc.err_db  = 1'b0;
        ifc.open_db = 1'b0;
        rep("rst", 2'd0, 1'b0, 1'b0, 2);

        // ON held through reset: no edge
        rst_n = 1'b1;
        rep("hold", 2'd0, 1'b0, 1'b0, 10);
        ifc.on_db = 1'b0;
        cyc("hold", 2'd0, 1'b0, 1'b0);

        // full run
        ifc.on_db = 1'b1;
        rep("start", 2'd1, 1'b1, 1'b0, 4);
        rep("run", 2'd1, 1'b0, 1'b0, 16);
        cyc("done", 2'd0, 1'b1, 1'b1);
        rep("dbeep", 2'd0, 1'b1, 1'b0, 3);
        cyc("idle", 2'd0, 1'b0, 1'b0);

        // door pause and resume
        ifc.on_db = 1'b0;
        cyc("s3", 2'd0, 1'b0, 1'b0);
        ifc.on_db = 1'b1;
        rep("r9", 2'd1, 1'b1, 1'b0, 4);
        rep("r9", 2'd1, 1'b0, 1'b0, 5);
        ifc.open_db = 1'b1;
        rep("door", 2'd2, 1'b0, 1'b0, 10);
        ifc.open_db = 1'b0;
        rep("dcls", 2'd2, 1'b0, 1'b0, 2);
        ifc.on_db = 1'b0;
        cyc("dcls", 2'd2, 1'b0, 1'b0);
        ifc.on_db = 1'b1;
        rep("resume", 2'd1, 1'b0, 1'b0, 12);
        cyc("done2", 2'd0, 1'b1, 1'b1);
        rep("dbeep2", 2'd0, 1'b1, 1'b0, 3);
        cyc("idle2", 2'd0, 1'b0, 1'b0);

        // reject with door open, then beep extension
        ifc.open_db = 1'b1;
        ifc.on_db   = 1'b0;
        cyc("rej", 2'd0, 1'b0, 1'b0);
        ifc.on_db = 1'b1;
        cyc("rej", 2'd0, 1'b1, 1'b0);
        ifc.on_db = 1'b0;
        cyc("rej", 2'd0, 1'b1, 1'b0);
        ifc.on_db = 1'b1;
        rep("ext", 2'd0, 1'b1, 1'b0, 4);
        cyc("ext", 2'd0, 1'b0, 1'b0);
        ifc.open_db = 1'b0;

        // fault entry mid-run with simultaneous ON edge
        ifc.on_db = 1'b0;
        cyc("s5", 2'd0, 1'b0, 1'b0);
        ifc.on_db = 1'b1;
        rep("f", 2'd1, 1'b1, 1'b0, 2);
        ifc.on_db = 1'b0;
        cyc("f", 2'd1, 1'b1, 1'b0);
        ifc.err_db = 1'b1;
        ifc.on_db  = 1'b1;
        rep("alm", 2'd3, 1'b1, 1'b0, 4);
        ifc.off_db = 1'b1;
        rep("alm", 2'd3, 1'b0, 1'b0, 4);
        rep("alm", 2'd3, 1'b1, 1'b0, 4);
        ifc.off_db = 1'b0;
        ifc.err_db = 1'b0;
        cyc("alm", 2'd3, 1'b0, 1'b0);
        ifc.off_db = 1'b1;
        rep("fexit", 2'd0, 1'b0, 1'b0, 2);

        // reset mid-run and mid-beep
        ifc.off_db = 1'b0;
        ifc.on_db  = 1'b0;
        cyc("s6", 2'd0, 1'b0, 1'b0);
        ifc.on_db = 1'b1;
        rep("g", 2'd1, 1'b1, 1'b0, 2);
        rst_n = 1'b0;
        cyc("rmid", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        rep("post", 2'd0, 1'b0, 1'b0, 25);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
